// File: rtl/oled_spi_master.sv
// oled_spi_master: FIFO-buffered SPI write master for the SSD1351 OLED, with burst
// transfers (nCS held across queued words) and a timed nRES pulse generator.
module oled_spi_master #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 2,
    parameter int CS_SETUP   = 1,
    parameter int CS_HOLD    = 1,
    parameter int RES_CYCLES = 20
) (
    input  logic                                Clock,
    input  logic                                nReset,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic                                wr_dc,
    input  logic                                rst_req,
    output logic                                busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
    output logic                                nRES,
    output logic                                SCLK,
    output logic                                SDIN,
    output logic                                DnC,
    output logic                                nCS
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET_PULSE, S_CS_SETUP, S_SHIFT_LOW, S_SHIFT_HIGH, S_CS_HOLD
    } state_t;

    state_t                state;
    logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]         wrPtr, rdPtr;
    logic [LW-1:0]         level, levelNext;
    logic                  isEmpty, notFull, pending;
    logic [15:0]           cnt;
    logic [BW-1:0]         bitCnt;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic                  push, pop, halfDone, lastBit;

    assign push      = wr_valid && notFull;
    assign halfDone  = cnt == 16'(CLK_DIV - 1);
    assign lastBit   = bitCnt == BW'(DATA_WIDTH - 1);
    // Pops happen only where the FSM loads the shifter: IDLE start or a burst reload.
    assign pop       = !isEmpty && !pending &&
                       (state == S_IDLE || (state == S_SHIFT_HIGH && halfDone && lastBit));
    assign levelNext = level + LW'(push) - LW'(pop);

    assign wr_ready   = notFull;
    assign fifo_level = level;
    assign SDIN       = shiftReg[DATA_WIDTH-1];
    assign busy       = state != S_IDLE || !isEmpty || pending;

    always_ff @(posedge Clock)
        if (push) mem[wrPtr] <= {wr_dc, wr_data};

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            level   <= '0;
            isEmpty <= 1'b1;
            notFull <= 1'b0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop) rdPtr <= rdPtr + PW'(1);
            level   <= levelNext;
            isEmpty <= levelNext == '0;
            notFull <= levelNext != LW'(FIFO_DEPTH);
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= S_RESET_PULSE;
            cnt      <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            pending  <= 1'b0;
            nRES     <= 1'b0;
            SCLK     <= 1'b0;
            DnC      <= 1'b0;
            nCS      <= 1'b1;
        end else begin
            pending <= rst_req || (pending && state != S_IDLE);
            cnt     <= cnt + 16'd1;
            case (state)
                S_IDLE: begin
                    SCLK <= 1'b0;
                    nCS  <= 1'b1;
                    cnt  <= '0;
                    if (pending) begin
                        state <= S_RESET_PULSE;
                        nRES  <= 1'b0;
                    end else if (!isEmpty) begin
                        state           <= S_CS_SETUP;
                        nCS             <= 1'b0;
                        {DnC, shiftReg} <= mem[rdPtr];
                        bitCnt          <= '0;
                    end
                end
                S_RESET_PULSE:
                    if (cnt == 16'(RES_CYCLES - 1)) begin
                        nRES  <= 1'b1;
                        state <= S_IDLE;
                    end
                S_CS_SETUP:
                    if (cnt == 16'(CS_SETUP - 1)) begin
                        cnt   <= '0;
                        state <= S_SHIFT_LOW;
                    end
                S_SHIFT_LOW:
                    if (halfDone) begin
                        cnt   <= '0;
                        SCLK  <= 1'b1;
                        state <= S_SHIFT_HIGH;
                    end
                S_SHIFT_HIGH:
                    if (halfDone) begin
                        cnt  <= '0;
                        SCLK <= 1'b0;
                        if (!lastBit) begin
                            shiftReg <= shiftReg << 1;
                            bitCnt   <= bitCnt + BW'(1);
                            state    <= S_SHIFT_LOW;
                        end else if (pop) begin
                            {DnC, shiftReg} <= mem[rdPtr];
                            bitCnt          <= '0;
                            state           <= S_SHIFT_LOW;
                        end else begin
                            state <= S_CS_HOLD;
                        end
                    end
                S_CS_HOLD:
                    if (cnt == 16'(CS_HOLD - 1)) begin
                        nCS   <= 1'b1;
                        state <= S_IDLE;
                    end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
